// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare + BTB branch predictor.
// BTB tag/target fields are held at BP_ADDR_W bits, so XLEN must not exceed 32.
package bp_pkg;

  localparam int BP_ADDR_W = 32;

  typedef enum logic [1:0] {
    PHT_SNT = 2'd0,
    PHT_WNT = 2'd1,
    PHT_WT  = 2'd2,
    PHT_ST  = 2'd3
  } pht_state_e;

  localparam pht_state_e PHT_RESET = PHT_WNT;

  typedef struct packed {
    logic                 valid;
    logic [BP_ADDR_W-1:0] tag;
    logic [BP_ADDR_W-1:0] target;
    logic                 is_cond;
  } btb_entry_t;

  // 2-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == 2'(PHT_ST)) ? cnt : cnt + 2'd1;
    end else begin
      nxt = (cnt == 2'(PHT_SNT)) ? cnt : cnt - 2'd1;
    end
    return nxt;
  endfunction

  // 32-bit event counter that sticks at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] cnt, input logic en);
    logic [31:0] nxt;
    if (en && (cnt != 32'hFFFF_FFFF)) begin
      nxt = cnt + 32'd1;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational read, synchronous write.
// Addresses are passed as word addresses (pc[XLEN-1:2]).
module bp_btb
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 32,
  parameter int IDX     = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-3:0] rd_word,
  output logic            rd_hit,
  output logic [XLEN-1:0] rd_target,
  output logic            rd_is_cond,
  input  logic            wr_en,
  input  logic [XLEN-3:0] wr_word,
  input  logic [XLEN-1:0] wr_target,
  input  logic            wr_is_cond
);

  btb_entry_t entry_q [ENTRIES];
  btb_entry_t entry_d [ENTRIES];
  btb_entry_t rd_entry;
  logic [IDX-1:0] rd_idx;
  logic [IDX-1:0] wr_idx;

  // Lookup: index by low word bits, hit on valid and full tag match.
  always_comb begin
    rd_idx     = rd_word[IDX-1:0];
    rd_entry   = entry_q[rd_idx];
    rd_hit     = rd_entry.valid && (rd_entry.tag == BP_ADDR_W'(rd_word[XLEN-3:IDX]));
    rd_target  = rd_entry.target[XLEN-1:0];
    rd_is_cond = rd_entry.is_cond;
  end

  // Allocation: a write simply overwrites whatever occupies the slot.
  always_comb begin
    entry_d = entry_q;
    wr_idx  = wr_word[IDX-1:0];
    if (wr_en) begin
      entry_d[wr_idx] = '{valid:   1'b1,
                          tag:     BP_ADDR_W'(wr_word[XLEN-3:IDX]),
                          target:  BP_ADDR_W'(wr_target),
                          is_cond: wr_is_cond};
    end else begin
      entry_d = entry_q;
    end
  end

  // Entry storage; reset clears every valid bit (whole entry zeroed).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// gshare direction predictor + direct-mapped BTB for the IF stage.
// Optional macro BP_STATS_EN adds saturating lookup/update/mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 32,
  parameter int GHR_BITS    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            fetch_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic [XLEN-1:0] pred_next_pc,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_is_cond,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_pred_taken,
  input  logic [XLEN-1:0] update_pred_tgt,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX = $clog2(BTB_ENTRIES);

  logic [1:0]          pht_q [BTB_ENTRIES];
  logic [1:0]          pht_d [BTB_ENTRIES];
  logic [GHR_BITS-1:0] ghr_q;
  logic [GHR_BITS-1:0] ghr_d;
  logic [IDX-1:0]      fetch_pidx;
  logic [IDX-1:0]      upd_pidx;
  logic                btb_hit;
  logic [XLEN-1:0]     btb_target;
  logic                btb_is_cond;

  bp_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES),
    .IDX     (IDX)
  ) u_btb (
    .clk        (clk),
    .rst        (reset),
    .rd_word    (fetch_pc[XLEN-1:2]),
    .rd_hit     (btb_hit),
    .rd_target  (btb_target),
    .rd_is_cond (btb_is_cond),
    .wr_en      (update_valid & update_taken),
    .wr_word    (update_pc[XLEN-1:2]),
    .wr_target  (update_target),
    .wr_is_cond (update_is_cond)
  );

  // Same-cycle prediction from pre-update BTB/PHT/GHR state.
  always_comb begin
    fetch_pidx  = fetch_pc[IDX+1:2] ^ IDX'(ghr_q);
    pred_taken  = 1'b0;
    pred_target = '0;
    if (btb_hit) begin
      pred_target = btb_target;
      pred_taken  = btb_is_cond ? pht_q[fetch_pidx][1] : 1'b1;
    end else begin
      pred_target = '0;
      pred_taken  = 1'b0;
    end
    pred_next_pc = pred_taken ? pred_target : fetch_pc + XLEN'(4);
  end

  // Misprediction detection and redirect address for the EX-stage branch.
  always_comb begin
    mispredict  = update_valid &
                  ((update_pred_taken != update_taken) |
                   (update_taken & (update_pred_tgt != update_target)));
    redirect_pc = update_taken ? update_target : update_pc + XLEN'(4);
  end

  // Conditional branches train the PHT at the pre-update history, then shift history.
  always_comb begin
    pht_d    = pht_q;
    ghr_d    = ghr_q;
    upd_pidx = update_pc[IDX+1:2] ^ IDX'(ghr_q);
    if (update_valid && update_is_cond) begin
      pht_d[upd_pidx] = pht_next(pht_q[upd_pidx], update_taken);
      ghr_d           = GHR_BITS'({ghr_q, update_taken});
    end else begin
      ghr_d = ghr_q;
    end
  end

  // PHT and global history state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        pht_q[i] <= 2'(PHT_RESET);
      end
      ghr_q <= '0;
    end else begin
      pht_q <= pht_d;
      ghr_q <= ghr_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] lookups_q, lookups_d;
  logic [31:0] updates_q, updates_d;
  logic [31:0] mispredicts_q, mispredicts_d;

  // Next values of the saturating event counters.
  always_comb begin
    lookups_d     = sat_inc32(lookups_q, fetch_valid);
    updates_d     = sat_inc32(updates_q, update_valid);
    mispredicts_d = sat_inc32(mispredicts_q, mispredict);
  end

  // Event counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lookups_q     <= 32'd0;
      updates_q     <= 32'd0;
      mispredicts_q <= 32'd0;
    end else begin
      lookups_q     <= lookups_d;
      updates_q     <= updates_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_updates     = updates_q;
  assign stat_mispredicts = mispredicts_q;
`else
  // fetch_valid only feeds the statistics counters.
  logic fetch_valid_unused;
  assign fetch_valid_unused = fetch_valid;
`endif

endmodule
